mem_port_arbiter: RTL and testbench

- Sequences the single-port unified memory between the instruction-fetch path and the data path. The data path is the load/store traffic produced when the main decoder asserts MemRead/MemWrite.
- Arbitrates between the two requesters and drives a ready/ack memory handshake.
- Bounds fetch starvation, detects memory timeouts, and parks the memory port when the core's halt opcode retires.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port unified memory between instruction
//               fetch and load/store traffic. It bounds fetch starvation,
//               aborts accesses that see no ack, and parks the port on halt.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int STREAK  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  input  logic          halt,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall,
  output logic          halted,
  output logic          mem_err
);

  localparam int SW = $clog2(STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_dm_req;
  logic            w_grant_fetch;
  logic            w_grant_data;
  logic            w_busy;
  logic            w_abort;
  logic            r_owner_data;
  logic            r_halt_pending;
  logic [SW-1:0]   r_streak;
  logic [TW-1:0]   r_tmo;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   r_if_rdata;
  logic [DW-1:0]   r_dm_rdata;
  logic            r_mem_err;

  assign w_dm_req = dm_read | dm_write;
  assign w_busy   = (r_state == S_FETCH) || (r_state == S_DATA);
  assign w_abort  = w_busy && !mem_ack && (r_tmo == TW'(TIMEOUT - 1));

  // State register; reset drops any in-flight access immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and grant decision. Data wins unless fetch has been starved.
  always_comb begin
    w_next        = r_state;
    w_grant_fetch = 1'b0;
    w_grant_data  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (halt || r_halt_pending) begin
          w_next = S_HALTED;
        end else if (w_dm_req && !(if_req && (r_streak == SW'(STREAK)))) begin
          w_next       = S_DATA;
          w_grant_data = 1'b1;
        end else if (if_req) begin
          w_next        = S_FETCH;
          w_grant_fetch = 1'b1;
        end
      end
      S_FETCH, S_DATA: begin
        if (mem_ack || w_abort) w_next = S_DONE;
      end
      S_DONE:   w_next = r_halt_pending ? S_HALTED : S_IDLE;
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  // Memory-side registers, read-data capture, streak/timeout counters, flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_if_rdata     <= '0;
      r_dm_rdata     <= '0;
      r_owner_data   <= 1'b0;
      r_halt_pending <= 1'b0;
      r_streak       <= '0;
      r_tmo          <= '0;
      r_mem_err      <= 1'b0;
    end else begin
      if (halt && (w_busy || (r_state == S_DONE))) r_halt_pending <= 1'b1;

      if (w_grant_data || w_grant_fetch) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= w_grant_data & dm_write;
        r_mem_addr   <= w_grant_data ? dm_addr : if_addr;
        r_owner_data <= w_grant_data;
        r_tmo        <= '0;
        if (w_grant_data) r_mem_wdata <= dm_wdata;
        // Only data grants that bypass a waiting fetch count toward the streak.
        if (w_grant_data && if_req) begin
          if (r_streak != SW'(STREAK)) r_streak <= r_streak + 1'b1;
        end else begin
          r_streak <= '0;
        end
      end else if (w_busy) begin
        if (mem_ack) begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          if (!r_owner_data)  r_if_rdata <= mem_rdata;
          else if (!r_mem_we) r_dm_rdata <= mem_rdata;
        end else if (w_abort) begin
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_mem_err <= 1'b1;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign mem_err   = r_mem_err;
  assign if_valid  = (r_state == S_DONE) && !r_owner_data;
  assign dm_valid  = (r_state == S_DONE) &&  r_owner_data;
  assign halted    = (r_state == S_HALTED);
  assign stall     = (if_req & ~if_valid) | (w_dm_req & ~dm_valid) |
                     (halted & (if_req | w_dm_req));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        halt;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        halted;
  logic        mem_err;

  int vectors    = 0;
  int miscompares = 0;
  int n;

  mem_port_arbiter #(.AW(32), .DW(32), .STREAK(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .halted(halted), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0;
    dm_addr = 0; dm_wdata = 0; halt = 0; mem_rdata = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b1;

    // ---- basic fetch with immediate ack ----
    @(negedge clk);
    if_req = 1; if_addr = 32'h40;
    #1 chk("f_stall_req", stall, 1);
    @(negedge clk);
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h40);
    chk("f_mem_we", mem_we, 0);
    chk("f_if_valid_early", if_valid, 0);
    mem_ack = 1; mem_rdata = 32'h00500093;
    @(negedge clk);
    chk("f_if_valid", if_valid, 1);
    chk("f_if_rdata", if_rdata, 32'h00500093);
    chk("f_mem_req_drop", mem_req, 0);
    chk("f_stall_valid", stall, 0);
    if_req = 0; mem_ack = 0;
    @(negedge clk);
    chk("f_if_valid_once", if_valid, 0);

    // ---- contention: data first, then fetch ----
    if_req = 1; if_addr = 32'h44; dm_read = 1; dm_addr = 32'h100;
    @(negedge clk);
    chk("c_mem_addr_data", mem_addr, 32'h100);
    chk("c_mem_we", mem_we, 0);
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("c_dm_valid", dm_valid, 1);
    chk("c_if_valid_not_yet", if_valid, 0);
    chk("c_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("c_if_rdata_kept", if_rdata, 32'h00500093);
    chk("c_stall_fetch_wait", stall, 1);
    dm_read = 0; mem_ack = 0;
    @(negedge clk);
    chk("c_idle_no_req", mem_req, 0);
    @(negedge clk);
    chk("c_fetch_addr", mem_addr, 32'h44);
    mem_ack = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("c_if_valid", if_valid, 1);
    chk("c_if_rdata", if_rdata, 32'h12345678);
    chk("c_dm_rdata_kept", dm_rdata, 32'hDEADBEEF);
    if_req = 0; mem_ack = 0;
    @(negedge clk);

    // ---- starvation: 4 stores, then fetch, then data again (streak cleared) ----
    if_req = 1; if_addr = 32'h80; dm_write = 1; dm_addr = 32'h200; dm_wdata = 32'h11;
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("s_grant%0d_req", i), mem_req, 1);
      chk($sformatf("s_grant%0d_we", i), mem_we, (i != 4));
      chk($sformatf("s_grant%0d_addr", i), mem_addr, (i != 4) ? 32'h200 : 32'h80);
      if (i != 4) chk($sformatf("s_grant%0d_wdata", i), mem_wdata, 32'h11);
      @(negedge clk);
      chk($sformatf("s_done%0d_dm_valid", i), dm_valid, (i != 4));
      chk($sformatf("s_done%0d_if_valid", i), if_valid, (i == 4));
      if (i == 5) begin if_req = 0; dm_write = 0; mem_ack = 0; end
      @(negedge clk);
    end
    chk("s_if_rdata", if_rdata, 32'hCAFEF00D);
    chk("s_dm_rdata_store_untouched", dm_rdata, 32'hDEADBEEF);

    // ---- timeout on a store ----
    dm_write = 1; dm_addr = 32'h300; dm_wdata = 32'h22;
    @(negedge clk);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t_req_cycles", n, 16);
    chk("t_dm_valid", dm_valid, 1);
    chk("t_mem_err", mem_err, 1);
    chk("t_mem_we_drop", mem_we, 0);
    dm_write = 0;
    @(negedge clk);
    dm_read = 1; dm_addr = 32'h304;
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("t2_dm_valid", dm_valid, 1);
    chk("t2_dm_rdata", dm_rdata, 32'hA5A5A5A5);
    chk("t2_mem_err_sticky", mem_err, 1);
    dm_read = 0; mem_ack = 0;
    @(negedge clk);

    // ---- halt during a load, ack three cycles later ----
    dm_read = 1; dm_addr = 32'h400;
    @(negedge clk);
    chk("h_mem_req", mem_req, 1);
    halt = 1;
    @(negedge clk);
    halt = 0;
    repeat (2) @(negedge clk);
    chk("h_still_waiting", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h0BADCAFE;
    @(negedge clk);
    chk("h_dm_valid", dm_valid, 1);
    chk("h_dm_rdata", dm_rdata, 32'h0BADCAFE);
    chk("h_not_halted_yet", halted, 0);
    dm_read = 0; mem_ack = 0;
    @(negedge clk);
    chk("h_halted", halted, 1);
    chk("h_mem_req_parked", mem_req, 0);
    if_req = 1; if_addr = 32'h48;
    #1 chk("h_stall", stall, 1);
    repeat (2) @(negedge clk);
    chk("h_mem_req_ignored", mem_req, 0);
    chk("h_still_halted", halted, 1);
    chk("h_if_valid_none", if_valid, 0);
    if_req = 0;

    // ---- async reset mid-fetch ----
    reset = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("r_unparked", halted, 0);
    chk("r_mem_err_cleared", mem_err, 0);
    if_req = 1; if_addr = 32'h50;
    @(negedge clk);
    chk("r_fetch_req", mem_req, 1);
    #2 reset = 0;
    #1;
    chk("r_async_req_drop", mem_req, 0);
    chk("r_async_if_rdata", if_rdata, 0);
    chk("r_async_no_valid", if_valid, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("r2_fetch_req", mem_req, 1);
    chk("r2_fetch_addr", mem_addr, 32'h50);
    mem_ack = 1; mem_rdata = 32'h00100073;
    @(negedge clk);
    chk("r2_if_valid", if_valid, 1);
    chk("r2_if_rdata", if_rdata, 32'h00100073);
    if_req = 0; mem_ack = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
